// File: rtl/toyrisc_pkg.sv
`default_nettype none
// toyrisc_pkg: shared ISA constants, instruction field layout and fetch FSM encoding.
// Rev 1.0
package toyrisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam int OP_W     = 6;
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int SEL_W    = 5;
  localparam int DEST_MSB = 25;
  localparam int DEST_LSB = 21;
  localparam int LEFT_MSB = 20;
  localparam int LEFT_LSB = 16;
  localparam int IMM_W    = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP = 6'h00;
  localparam logic [OP_W-1:0] OP_LDI = 6'h01;
  localparam logic [OP_W-1:0] OP_ADD = 6'h02;
  localparam logic [OP_W-1:0] OP_SUB = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OP_W-1:0] OP_JMP = 6'h05;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// fetch_timer: request wait counter; expired flags the LIMIT-th counted cycle.
// Rev 1.0
module fetch_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Asserted during the cycle whose un-acked edge would bring the count to LIMIT.
  assign expired = count && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: single-outstanding instruction fetch with held IR and sticky timeout.
// Rev 1.0
module fetch_unit
  import toyrisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  next_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op_code,
  output logic [SEL_W-1:0]   dest_sel,
  output logic [SEL_W-1:0]   left_sel,
  output logic [IMM_W-1:0]   jmp_val,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
);

  fetch_state_t state, state_nxt;
  logic load_ir;
  logic load_pc;
  logic timer_clear;
  logic timer_count;
  logic timer_expired;

  // Counter is held at zero outside S_REQ so every request starts fresh.
  assign timer_clear = (state != S_REQ);
  assign timer_count = (state == S_REQ) && !imem_ack;

  fetch_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .count  (timer_count),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!halt) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = S_VALID;
        end else if (timer_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          load_pc   = 1'b1;
          state_nxt = halt ? S_IDLE : S_REQ;
        end
      end
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= {OP_NOP, {(INSTR_W - OP_W){1'b0}}};
    end else begin
      if (load_pc) pc <= next_addr;
      if (load_ir) instr <= imem_rdata;
    end
  end

  assign imem_req    = (state == S_REQ);
  assign instr_valid = (state == S_VALID);
  assign fetch_err   = (state == S_ERR);
  assign imem_addr   = pc;

  assign op_code  = instr[OP_MSB:OP_LSB];
  assign dest_sel = instr[DEST_MSB:DEST_LSB];
  assign left_sel = instr[LEFT_MSB:LEFT_LSB];
  assign jmp_val  = instr[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire
